oled_spi_rx: RTL

- SPI responder and command decoder for the SSD1306-style OLED link, i.e. the panel side of the serial command stream our OLED driver emits.
- Oversamples cs/sclk/sdin/dc/res on the system clock, assembles bytes MSB-first and decodes the command set used by our startup and shutdown sequences into a shadow register file.
- Used as a synthesizable loopback/monitor in simulation and on-board self-test. Also forwards pixel data bytes downstream.

---
 rtl/oled_pkg.sv | 25 ++
 rtl/spi_byte_rx.sv | 74 +++++++
 rtl/oled_spi_rx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// Shared opcode constants, decoder state type and shadow defaults for the OLED link
// (used by both the driver and the oled_spi_rx responder).
package oled_pkg;

    localparam logic [7:0] OP_DISP_OFF  = 8'hAE;
    localparam logic [7:0] OP_DISP_ON   = 8'hAF;
    localparam logic [7:0] OP_SEG0      = 8'hA0;
    localparam logic [7:0] OP_SEG1      = 8'hA1;
    localparam logic [7:0] OP_COM_NORM  = 8'hC0;
    localparam logic [7:0] OP_COM_REV   = 8'hC8;
    localparam logic [7:0] OP_CHG_PUMP  = 8'h8D;
    localparam logic [7:0] OP_PRECHG    = 8'hD9;
    localparam logic [7:0] OP_COMCFG    = 8'hDA;
    localparam logic [7:0] OP_ADDR_MODE = 8'h20;

    localparam logic [7:0] PRECHARGE_RST = 8'h22;
    localparam logic [7:0] COMCFG_RST    = 8'h12;
    localparam logic [1:0] ADDR_MODE_RST = 2'b10;

    typedef enum logic {
        ST_CMD,
        ST_ARG
    } dec_state_t;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI byte receiver: input synchronizers, sclk edge detect, MSB-first shifter and
// frame-abort detection. Emits a one-cycle byte strobe with the latched byte and dc.
module spi_byte_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cs,
    input  logic       sclk,
    input  logic       sdin,
    input  logic       dc,
    input  logic       res,
    output logic       strobe,
    output logic [7:0] rx_byte,
    output logic       rx_dc,
    output logic       abort,
    output logic       res_s
);

    // Idle pattern {cs, sclk, sdin, dc, res}: deselected, panel held in reset
    localparam logic [4:0] SYNC_RST = 5'b1_0_0_0_0;

    logic [4:0] sync_q [SYNC_STAGES];
    logic       cs_s, sclk_s, sdin_s, dc_s;
    logic       cs_q, sclk_q;
    logic [2:0] cnt;
    logic [6:0] sreg;
    logic       done;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
        end else begin
            sync_q[0] <= {cs, sclk, sdin, dc, res};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {cs_s, sclk_s, sdin_s, dc_s, res_s} = sync_q[SYNC_STAGES-1];

    // done marks the 8th bit; strobe follows one cycle later
    always_ff @(posedge clock) begin
        if (reset || !res_s) begin
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            cnt     <= '0;
            sreg    <= '0;
            rx_byte <= '0;
            rx_dc   <= 1'b0;
            done    <= 1'b0;
            strobe  <= 1'b0;
            abort   <= 1'b0;
        end else begin
            cs_q   <= cs_s;
            sclk_q <= sclk_s;
            done   <= 1'b0;
            strobe <= done;
            abort  <= 1'b0;
            if (cs_s && !cs_q && cnt != 3'd0) begin
                cnt   <= '0;
                abort <= 1'b1;
            end else if (!cs_s && sclk_s && !sclk_q) begin
                sreg <= {sreg[5:0], sdin_s};
                cnt  <= 3'(cnt + 3'd1);
                if (cnt == 3'd7) begin
                    rx_byte <= {sreg, sdin_s};
                    rx_dc   <= dc_s;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/oled_spi_rx.sv
// OLED SPI responder: decodes the SSD1306-style command stream into shadow registers
// and forwards data bytes. Optional power-sequence checker: OLED_SPI_RX_SEQCHECK_EN.
module oled_spi_rx
    import oled_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic [7:0]  PRECHARGE_DEF = PRECHARGE_RST,
    parameter logic [7:0]  COMCFG_DEF    = COMCFG_RST
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cs,
    input  logic       sclk,
    input  logic       sdin,
    input  logic       dc,
    input  logic       res,
    input  logic       vbatc,
    input  logic       vddc,
    output logic       data_valid,
    output logic [7:0] data_byte,
    output logic       display_on,
    output logic       seg_remap,
    output logic       com_rev,
    output logic       charge_pump,
    output logic [7:0] precharge,
    output logic [7:0] com_cfg,
    output logic [1:0] addr_mode,
    output logic       unknown_cmd,
`ifdef OLED_SPI_RX_SEQCHECK_EN
    output logic       seq_err,
`endif
    output logic       proto_err
);

    logic       strobe, rx_dc, abort, res_s;
    logic [7:0] rx_byte;
    logic [7:0] pend_op;
    dec_state_t state;

    spi_byte_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .clock   (clock),
        .reset   (reset),
        .cs      (cs),
        .sclk    (sclk),
        .sdin    (sdin),
        .dc      (dc),
        .res     (res),
        .strobe  (strobe),
        .rx_byte (rx_byte),
        .rx_dc   (rx_dc),
        .abort   (abort),
        .res_s   (res_s)
    );

    always_ff @(posedge clock) begin
        if (reset || !res_s) begin
            state       <= ST_CMD;
            pend_op     <= '0;
            data_valid  <= 1'b0;
            data_byte   <= '0;
            display_on  <= 1'b0;
            seg_remap   <= 1'b0;
            com_rev     <= 1'b0;
            charge_pump <= 1'b0;
            precharge   <= PRECHARGE_DEF;
            com_cfg     <= COMCFG_DEF;
            addr_mode   <= ADDR_MODE_RST;
            unknown_cmd <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            unknown_cmd <= 1'b0;
            proto_err   <= abort;
            if (strobe) begin
                case (state)
                    ST_CMD: begin
                        if (rx_dc) begin
                            data_valid <= 1'b1;
                            data_byte  <= rx_byte;
                        end else begin
                            case (rx_byte)
                                OP_DISP_OFF: display_on <= 1'b0;
                                OP_DISP_ON:  display_on <= 1'b1;
                                OP_SEG0:     seg_remap  <= 1'b0;
                                OP_SEG1:     seg_remap  <= 1'b1;
                                OP_COM_NORM: com_rev    <= 1'b0;
                                OP_COM_REV:  com_rev    <= 1'b1;
                                OP_CHG_PUMP, OP_PRECHG, OP_COMCFG, OP_ADDR_MODE: begin
                                    pend_op <= rx_byte;
                                    state   <= ST_ARG;
                                end
                                default:     unknown_cmd <= 1'b1;
                            endcase
                        end
                    end
                    ST_ARG: begin
                        state <= ST_CMD;
                        if (rx_dc) begin
                            // Missing argument: the data byte is still forwarded
                            proto_err  <= 1'b1;
                            data_valid <= 1'b1;
                            data_byte  <= rx_byte;
                        end else begin
                            case (pend_op)
                                OP_CHG_PUMP:  charge_pump <= rx_byte[2];
                                OP_PRECHG:    precharge   <= rx_byte;
                                OP_COMCFG:    com_cfg     <= rx_byte;
                                OP_ADDR_MODE: addr_mode   <= rx_byte[1:0];
                                default:      ;
                            endcase
                        end
                    end
                    default: state <= ST_CMD;
                endcase
            end
        end
    end

`ifdef OLED_SPI_RX_SEQCHECK_EN
    // Bit 1 = vbatc, bit 0 = vddc; both active low, idle value is supply off
    logic [1:0] pwr_sync [SYNC_STAGES];
    logic [1:0] pwr_s, pwr_q;
    logic       disp_q;

    assign pwr_s = pwr_sync[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) pwr_sync[i] <= '1;
            pwr_q   <= '1;
            disp_q  <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            pwr_sync[0] <= {vbatc, vddc};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) pwr_sync[i] <= pwr_sync[i-1];
            pwr_q  <= pwr_s;
            disp_q <= display_on;
            if ((pwr_q[1] && !pwr_s[1] && pwr_s[0]) ||
                (display_on && !disp_q && !charge_pump) ||
                (!pwr_q[0] && pwr_s[0] && !pwr_s[1]))
                seq_err <= 1'b1;
        end
    end
`else
    logic unused_pwr;
    assign unused_pwr = vbatc ^ vddc;
`endif

endmodule
